// File: rtl/tt_um_digital_gates.sv
`default_nettype none
// ============================================================================
// Module   : tt_um_digital_gates
// Purpose  : Tiny Tapeout tile evaluating all eight two-input logic functions
//            of A = ui_in[0] and B = ui_in[1], registered onto uo_out.
// Options  : GATE_DBG_EN - drives uio_out with a registered count of
//            input-change events and enables the uio bank as outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tt_um_digital_gates (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  logic       a_w;
  logic       b_w;
  logic [7:0] gates_d;
  logic [7:0] gates_q;

  assign a_w = ui_in[0];
  assign b_w = ui_in[1];

  // Gate results in output bit order: AND, OR, XOR, NAND, NOR, XNOR, ~A, ~B
  always_comb begin
    gates_d    = 8'h00;
    gates_d[0] = a_w & b_w;
    gates_d[1] = a_w | b_w;
    gates_d[2] = a_w ^ b_w;
    gates_d[3] = ~(a_w & b_w);
    gates_d[4] = ~(a_w | b_w);
    gates_d[5] = ~(a_w ^ b_w);
    gates_d[6] = ~a_w;
    gates_d[7] = ~b_w;
  end

  // Output register: reset wins over enable; ena low holds the last result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gates_q <= 8'h00;
    end else if (ena) begin
      gates_q <= gates_d;
    end
  end

  assign uo_out = gates_q;

`ifdef GATE_DBG_EN
  logic [1:0] prev_ab_q;
  logic [7:0] chg_cnt_d;
  logic [7:0] chg_cnt_q;

  // Count one event whenever {B,A} differs from the pair seen at the last enabled edge
  always_comb begin
    chg_cnt_d = chg_cnt_q;
    if ({b_w, a_w} != prev_ab_q) begin
      chg_cnt_d = chg_cnt_q + 8'd1;
    end
  end

  // Debug state: previous operand pair and wrapping change counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_ab_q <= 2'b00;
      chg_cnt_q <= 8'h00;
    end else if (ena) begin
      prev_ab_q <= {b_w, a_w};
      chg_cnt_q <= chg_cnt_d;
    end
  end

  assign uio_out = chg_cnt_q;
  assign uio_oe  = 8'hFF;
`else
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;
`endif

  // Operand bits [7:2] and the bidirectional inputs are intentionally unused
  logic unused_inputs_w;
  assign unused_inputs_w = &{1'b0, ui_in[7:2], uio_in};

endmodule
`default_nettype wire

// File: tb/tb_tt_um_digital_gates.sv
`default_nettype none
// ============================================================================
// Module   : tb_tt_um_digital_gates
// Purpose  : Randomized self-checking bench for tt_um_digital_gates against a
//            truth-table reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tt_um_digital_gates;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks;
  int errors;

  // Reference model state
  logic [3:0] truth_tab [8];
  logic [7:0] m_uo;
  logic [1:0] m_prev;
  int         m_cnt;
  bit         m_valid;

  tt_um_digital_gates dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%02h exp=%02h at %0t", tag, got, exp, $time);
    end
  endtask

  // Each gate is described by its 4-entry truth table indexed by {B,A}
  function automatic logic [7:0] gate_ref(input logic a, input logic b);
    logic [7:0] r;
    logic [3:0] t;
    int idx;
    idx = (b ? 2 : 0) + (a ? 1 : 0);
    for (int g = 0; g < 8; g++) begin
      t    = truth_tab[g];
      r[g] = t[idx];
    end
    return r;
  endfunction

  // Apply one cycle of stimulus, check no early change, then check after the edge
  task automatic tick(input logic rv, input logic ev, input logic [7:0] uv, input logic [7:0] iv);
    logic [7:0] exp_dbg;
    logic [7:0] exp_oe;
    rst_n  = rv;
    ena    = ev;
    ui_in  = uv;
    uio_in = iv;
    #1;
    if (m_valid) check("pre_edge_hold", uo_out, m_uo);
    @(posedge clk);
    if (!rv) begin
      m_uo    = 8'h00;
      m_prev  = 2'b00;
      m_cnt   = 0;
      m_valid = 1'b1;
    end else if (ev) begin
      m_uo = gate_ref(uv[0], uv[1]);
      if (uv[1:0] != m_prev) m_cnt = (m_cnt + 1) % 256;
      m_prev = uv[1:0];
    end
    #1;
    if (m_valid) begin
`ifdef GATE_DBG_EN
      exp_dbg = 8'(m_cnt);
      exp_oe  = 8'hFF;
`else
      exp_dbg = 8'h00;
      exp_oe  = 8'h00;
`endif
      check("uo_out", uo_out, m_uo);
      check("uio_out", uio_out, exp_dbg);
      check("uio_oe", uio_oe, exp_oe);
      if (rv && ev) begin
        check("inv_nand_nor_xnor", {5'b0, uo_out[5:3]}, {5'b0, ~uo_out[2:0]});
        check("inv_not_xor", {7'b0, uo_out[6] ^ uo_out[7]}, {7'b0, uo_out[2]});
      end
    end
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] held;
    checks  = 0;
    errors  = 0;
    m_uo    = 8'h00;
    m_prev  = 2'b00;
    m_cnt   = 0;
    m_valid = 1'b0;
    // Truth tables, bit i = output for {B,A} == i
    truth_tab[0] = 4'b1000; // AND
    truth_tab[1] = 4'b1110; // OR
    truth_tab[2] = 4'b0110; // XOR
    truth_tab[3] = 4'b0111; // NAND
    truth_tab[4] = 4'b0001; // NOR
    truth_tab[5] = 4'b1001; // XNOR
    truth_tab[6] = 4'b0101; // NOT A
    truth_tab[7] = 4'b0011; // NOT B
    rst_n  = 1'b0;
    ena    = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;

    // Reset with ena low
    tick(1'b0, 1'b0, 8'h00, 8'h00);
    check("reset_uo", uo_out, 8'h00);

    // Fixed-value anchors for the truth table
    tick(1'b1, 1'b1, 8'h00, 8'h00);
    check("tt_b0a0", uo_out, 8'hF8);
    tick(1'b1, 1'b1, 8'h02, 8'h00);
    tick(1'b1, 1'b1, 8'h01, 8'h00);
    tick(1'b1, 1'b1, 8'h03, 8'h00);
    check("tt_b1a1", uo_out, 8'h23);

    // Enable hold: inputs change while ena low
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 8'h00, 8'h00);
    check("hold_ena_low", uo_out, 8'h23);
    tick(1'b1, 1'b1, 8'h00, 8'h00);
    check("reenable", uo_out, 8'hF8);

    // Reset mid-run with ena high, then reload
    tick(1'b1, 1'b1, 8'h02, 8'h00);
    tick(1'b0, 1'b1, 8'h02, 8'h00);
    check("reset_midrun", uo_out, 8'h00);
    tick(1'b1, 1'b1, 8'h02, 8'h00);

    // Ignored inputs: A,B fixed, everything else random
    held = uo_out;
    for (int i = 0; i < 50; i++) begin
      r = 8'($urandom);
      tick(1'b1, 1'b1, {r[7:2], 2'b10}, 8'($urandom));
    end
    check("ignored_inputs_const", uo_out, held);

    // Fully random stimulus with occasional reset and random enable
    for (int i = 0; i < 300; i++) begin
      tick(($urandom_range(0, 15) != 0), 1'($urandom), 8'($urandom), 8'($urandom));
    end

    // Change counter: toggle A for 260 enabled cycles, then hold
    tick(1'b0, 1'b1, 8'h00, 8'h00);
    for (int i = 0; i < 260; i++) begin
      tick(1'b1, 1'b1, {7'b0, ~ui_in[0]}, 8'($urandom));
    end
`ifdef GATE_DBG_EN
    check("dbg_260_wrap", uio_out, 8'h04);
`endif
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, ui_in, 8'($urandom));
`ifdef GATE_DBG_EN
    check("dbg_hold_const", uio_out, 8'h04);
`else
    check("dbg_off_uio_oe", uio_oe, 8'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
